// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port bus arbiter between instruction fetch and load/store
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of data-over-instruction priority.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  logic [1:0]  state;
  logic        owner;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_wdata;

  logic        grant_data;
  logic        misaligned;
  logic [3:0]  data_strb;
  logic [31:0] data_wrep;

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  // On a tie the requester that did not win the previous grant goes first.
  assign grant_data = data_req & (~inst_req | (last_owner == OWNER_INST));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_owner <= OWNER_INST;
    end else if (state == ST_IDLE && (inst_req || data_req)) begin
      last_owner <= grant_data ? OWNER_DATA : OWNER_INST;
    end
  end
`else
  assign grant_data = data_req;
`endif

  always_comb begin
    misaligned = 1'b0;
    case (data_size)
      2'b01:   misaligned = data_addr[0];
      2'b10:   misaligned = (data_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    data_strb = 4'b0000;
    data_wrep = data_wdata;
    case (data_size)
      2'b00: begin
        data_strb = 4'b1000 >> data_addr[1:0];
        data_wrep = {4{data_wdata[7:0]}};
      end
      2'b01: begin
        data_strb = data_addr[1] ? 4'b0011 : 4'b1100;
        data_wrep = {2{data_wdata[15:0]}};
      end
      2'b10:   data_strb = 4'b1111;
      default: data_strb = 4'b0000;
    endcase
    if (!data_wr) begin
      data_strb = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= OWNER_INST;
      lat_wr    <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= 32'h0;
      lat_wstrb <= 4'b0000;
      lat_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_data) begin
            owner     <= OWNER_DATA;
            lat_wr    <= data_wr;
            lat_size  <= data_size;
            lat_addr  <= data_addr;
            lat_wstrb <= data_strb;
            lat_wdata <= data_wrep;
            state     <= misaligned ? ST_ERR : ST_ADDR;
          end else if (inst_req) begin
            owner     <= OWNER_INST;
            lat_wr    <= 1'b0;
            lat_size  <= 2'b10;
            lat_addr  <= inst_addr;
            lat_wstrb <= 4'b0000;
            lat_wdata <= 32'h0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: if (bus_addr_ok) state <= ST_DATA;
        ST_DATA: if (bus_data_ok) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic in_addr;
  logic in_data;
  assign in_addr = (state == ST_ADDR);
  assign in_data = (state == ST_DATA);

  assign bus_req   = in_addr;
  assign bus_wr    = lat_wr;
  assign bus_size  = lat_size;
  assign bus_addr  = lat_addr;
  assign bus_wstrb = lat_wstrb;
  assign bus_wdata = lat_wdata;

  assign inst_addr_ok = in_addr & bus_addr_ok & (owner == OWNER_INST);
  assign data_addr_ok = in_addr & bus_addr_ok & (owner == OWNER_DATA);
  assign inst_data_ok = in_data & bus_data_ok & (owner == OWNER_INST);
  assign data_data_ok = in_data & bus_data_ok & (owner == OWNER_DATA);

  // Read data is forced to zero outside the owner's response window.
  assign inst_rdata = (in_data && owner == OWNER_INST) ? bus_rdata : 32'h0;
  assign data_rdata = (in_data && owner == OWNER_DATA) ? bus_rdata : 32'h0;

  assign data_err = (state == ST_ERR);
  assign busy     = (state != ST_IDLE);

endmodule
